// File: rtl/thermo_adc_sampler.sv
// Periodic LTC2308-style SPI ADC sampler with a sample FIFO drained over a
// 3-register Avalon-MM slave (DATA / STATUS / CTRL).
module thermo_adc_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int TCONV_CYC     = 100,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TW   = $clog2(SAMPLE_PERIOD);
  localparam int CMAX = (TCONV_CYC > 2*CLK_DIV) ? TCONV_CYC : 2*CLK_DIV;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, CONV, WAIT, SHIFT, STORE} state_t;

  state_t            state;
  logic              enable, overflow;
  logic [2:0]        ch;
  logic [TW-1:0]     timer;
  logic              tick;
  logic [CW-1:0]     cnt;
  logic [3:0]        bit_idx;
  logic [11:0]       cfg, sample;
  logic [11:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, push, pop, do_push, ovf_set, ctrl_wr;
  logic              unused_wd;

  assign unused_wd = ^avs_writedata[31:5];
  assign tick      = enable && (timer == TW'(SAMPLE_PERIOD - 1));
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = (state == STORE);
  assign pop       = avs_read && (avs_address == 2'd0) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push   = push && (!full || pop);
  assign ovf_set   = push && full && !pop;
  assign ctrl_wr   = avs_write && (avs_address == 2'd2);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  timer <= '0;
    else if (!enable || tick) timer <= '0;
    else                 timer <= timer + 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      cfg        <= '0;
      sample     <= '0;
      adc_convst <= 1'b0;
      adc_sck    <= 1'b0;
      adc_sdi    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          state      <= CONV;
          cnt        <= '0;
          adc_convst <= 1'b1;
          cfg        <= {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0, 6'b0};
        end
        CONV: if (cnt == CW'(1)) begin
          state      <= WAIT;
          cnt        <= '0;
          adc_convst <= 1'b0;
        end else cnt <= cnt + 1'b1;
        WAIT: if (cnt == CW'(TCONV_CYC - 1)) begin
          state   <= SHIFT;
          cnt     <= '0;
          bit_idx <= '0;
          adc_sdi <= cfg[11];
          cfg     <= cfg << 1;
        end else cnt <= cnt + 1'b1;
        SHIFT: begin
          // Low half then high half of each bit; SDO is captured as SCK rises.
          if (cnt == CW'(CLK_DIV - 1)) begin
            adc_sck <= 1'b1;
            sample  <= {sample[10:0], adc_sdo};
          end
          if (cnt == CW'(2*CLK_DIV - 1)) begin
            cnt     <= '0;
            adc_sck <= 1'b0;
            if (bit_idx == 4'd11) begin
              state   <= STORE;
              adc_sdi <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              adc_sdi <= cfg[11];
              cfg     <= cfg << 1;
            end
          end else cnt <= cnt + 1'b1;
        end
        STORE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (do_push) mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b0;
      ch       <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)                        overflow <= 1'b1;
      else if (ctrl_wr && avs_writedata[1]) overflow <= 1'b0;
      if (ctrl_wr) begin
        enable <= avs_writedata[0];
        ch     <= avs_writedata[4:2];
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) avs_readdata <= '0;
    else if (avs_read) begin
      case (avs_address)
        2'd0:    avs_readdata <= empty ? 32'd0 : {1'b1, 19'b0, mem[rd_ptr]};
        2'd1:    avs_readdata <= {overflow, 15'b0, {(15-AW){1'b0}}, count};
        2'd2:    avs_readdata <= {27'b0, ch, 1'b0, enable};
        default: avs_readdata <= 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_thermo_adc_sampler.sv
// Randomized bench for thermo_adc_sampler: ADC/SPI model plus a queue-based
// model of the sample FIFO, overflow flag and register map.
module tb_thermo_adc_sampler;
  localparam int CLK_DIV = 4;
  localparam int TCONV   = 20;
  localparam int PERIOD  = 200;
  localparam int DEPTH   = 16;
  localparam int LAT     = 2 + TCONV + 24*CLK_DIV + 1;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b1;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        adc_convst, adc_sck, adc_sdi;
  logic        adc_sdo = 1'b0;

  thermo_adc_sampler #(.CLK_DIV(CLK_DIV), .TCONV_CYC(TCONV), .SAMPLE_PERIOD(PERIOD),
                       .FIFO_DEPTH(DEPTH)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .adc_convst(adc_convst), .adc_sck(adc_sck),
    .adc_sdi(adc_sdi), .adc_sdo(adc_sdo));

  always #5 clk_clk = ~clk_clk;

  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [11:0] mq[$];
  bit          m_ovf = 0;
  logic [2:0]  m_ch = '0;
  int          npush = 0;
  bit          force_en = 0;
  logic [11:0] force_word = '0;

  // ADC model and frame-level push scheduling
  logic [11:0] adc_word, sdi_cap, exp_cfg;
  int          sdo_bit, sdi_n;
  time         conv_t0, conv_w, sck_prev, sck_per, last_rise, conv_int;

  always begin
    logic [11:0] w;
    bit ab;
    @(posedge adc_convst);
    adc_word = force_en ? force_word : 12'($urandom);
    exp_cfg  = {1'b1, m_ch[0], m_ch[2], m_ch[1], 1'b1, 1'b0, 6'b0};
    sdi_n = 0; sdo_bit = 11; adc_sdo = adc_word[11];
    conv_t0 = $time; sck_prev = 0;
    if (last_rise != 0) conv_int = $time - last_rise;
    last_rise = $time;
    w = adc_word; ab = 0;
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk_clk);
      if (!reset_reset_n) ab = 1;
    end
    if (!ab && reset_reset_n) begin
      npush++;
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(w);
    end
  end

  always @(negedge adc_convst) conv_w = $time - conv_t0;

  always @(negedge adc_sck) if (sdo_bit > 0) begin
    sdo_bit--;
    adc_sdo = adc_word[sdo_bit];
  end

  always @(posedge adc_sck) begin
    sdi_cap = {sdi_cap[10:0], adc_sdi};
    sdi_n++;
    if (sck_prev != 0) sck_per = $time - sck_prev;
    sck_prev = $time;
    if (sdi_n == 12) chk("sdi_cfg", {20'b0, sdi_cap}, {20'b0, exp_cfg});
  end

  task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk_clk); #1;
    avs_read = 1'b0; d = avs_readdata;
  endtask

  task automatic avs_wr(input logic [1:0] a, input logic [31:0] v);
    avs_address = a; avs_writedata = v; avs_write = 1'b1;
    @(posedge clk_clk); #1;
    avs_write = 1'b0;
    if (a == 2'd2) begin
      m_ch = v[4:2];
      if (v[1]) m_ovf = 0;
    end
  endtask

  task automatic rd_status(input string tag);
    logic [31:0] d, e;
    e = {m_ovf, 15'b0, 16'(mq.size())};
    avs_rd(2'd1, d);
    chk(tag, d, e);
  endtask

  task automatic rd_data(input string tag, output logic [31:0] d);
    logic [31:0] e;
    e = 32'd0;
    if (mq.size() != 0) e = {1'b1, 19'b0, mq.pop_front()};
    avs_rd(2'd0, d);
    chk(tag, d, e);
  endtask

  task automatic wait_pushes(input int target, input string tag);
    for (int i = 0; i < 20*PERIOD*DEPTH; i++) begin
      if (npush >= target) break;
      @(posedge clk_clk); #1;
    end
    chk(tag, npush, target);
  endtask

  task automatic wait_convst(input string tag);
    bit seen = 0;
    for (int i = 0; i < 3*PERIOD; i++) begin
      @(posedge clk_clk); #1;
      if (adc_convst) begin seen = 1; break; end
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int tgt;
    last_rise = 0; conv_int = 0; conv_w = 0; sck_per = 0;
    #2 reset_reset_n = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    chk("rst_outputs", {28'b0, adc_convst, adc_sck, adc_sdi, 1'b0}, 32'd0);
    chk("rst_readdata", avs_readdata, 32'd0);
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;

    // Reset state through the register map
    rd_status("status_reset");
    rd_data("data_empty", d);
    rd_status("status_after_empty_read");
    avs_rd(2'd3, d);
    chk("addr3_read", d, 32'd0);
    avs_wr(2'd3, 32'hFFFF_FFFF);
    avs_rd(2'd2, d);
    chk("ctrl_after_addr3_wr", d, 32'd0);

    // Fixed sample 0xA5C on channel 0
    force_en = 1; force_word = 12'hA5C;
    tgt = npush + 1;
    avs_wr(2'd2, 32'h1);
    wait_pushes(tgt, "frame_a5c");
    avs_wr(2'd2, 32'h0);
    chk("sck_period", 32'(sck_per), 32'(2*CLK_DIV*10));
    chk("convst_width", 32'(conv_w), 32'd20);
    rd_data("data_a5c_model", d);
    chk("data_a5c", d, 32'h8000_0A5C);
    repeat (5) @(posedge clk_clk);
    #1 chk("readdata_hold", avs_readdata, 32'h8000_0A5C);
    force_en = 0;

    // Channel 3, enable cleared mid-frame: frame still lands, no further tick
    avs_wr(2'd2, 32'h0D);
    avs_rd(2'd2, d);
    chk("ctrl_read", d, 32'h0000_000D);
    tgt = npush + 1;
    wait_convst("convst_ch3");
    avs_wr(2'd2, 32'h0C);
    wait_pushes(tgt, "frame_ch3");
    chk("convst_width_ch3", 32'(conv_w), 32'd20);
    repeat (2*PERIOD) @(posedge clk_clk);
    #1 chk("no_tick_after_disable", npush, tgt);
    rd_status("status_one");
    rd_data("data_ch3", d);

    // Random channels and samples
    for (int k = 0; k < 4; k++) begin
      logic [2:0] c;
      c = 3'($urandom_range(0, 7));
      tgt = npush + 1;
      avs_wr(2'd2, {27'b0, c, 2'b01});
      wait_pushes(tgt, "frame_rand");
      avs_wr(2'd2, 32'h0);
      rd_status("status_rand");
      rd_data("data_rand", d);
    end

    // Overflow: 17 samples unread
    last_rise = 0;
    tgt = npush + 17;
    avs_wr(2'd2, 32'h1);
    wait_pushes(tgt, "frames_17");
    avs_wr(2'd2, 32'h0);
    chk("tick_period", 32'(conv_int), 32'(PERIOD*10));
    avs_rd(2'd1, d);
    chk("status_overflow", d, 32'h8000_0010);
    avs_wr(2'd2, 32'h3);
    avs_wr(2'd2, 32'h0);
    rd_status("status_ovf_cleared");
    for (int k = 0; k < 16; k++) rd_data("drain_ovf", d);
    rd_status("status_drained");

    // Full FIFO with a DATA read landing in the STORE cycle
    tgt = npush + 16;
    avs_wr(2'd2, 32'h1);
    wait_pushes(tgt, "fill_16");
    wait_convst("convst_17th");
    repeat (LAT - 1) @(posedge clk_clk);
    #1 rd_data("data_in_store", d);
    avs_wr(2'd2, 32'h0);
    chk("push_in_store", npush, tgt + 1);
    avs_rd(2'd1, d);
    chk("status_pop_push_full", d, 32'h0000_0010);
    for (int k = 0; k < 16; k++) rd_data("drain_full", d);

    // Reset asserted mid-SHIFT
    avs_wr(2'd2, 32'h1);
    begin
      bit seen = 0;
      for (int i = 0; i < 3*PERIOD; i++) begin
        @(posedge clk_clk); #3;
        if (adc_sck) begin seen = 1; break; end
      end
      chk("sck_seen", {31'b0, seen}, 32'd1);
    end
    reset_reset_n = 1'b0;
    #1;
    chk("rst_async_outputs", {29'b0, adc_convst, adc_sck, adc_sdi}, 32'd0);
    mq.delete(); m_ovf = 0; m_ch = '0;
    repeat (3) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    rd_status("status_after_reset");
    repeat (2*PERIOD) @(posedge clk_clk);
    #1 rd_data("data_after_reset", d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
